bus_demux_1_4: RTL and testbench
================================

Name: bus_demux_1_4

Overview:
- Routes one data-memory bus initiator (core load/store unit) to one of four memory-mapped targets (RAM, ROM, GPIO, timer), selected by two address bits.
- Carries the response from the selected target back to the initiator.
- Allows one outstanding transaction at a time. A per-transaction timeout and a target-enable mask turn missing or absent targets into error responses, so the core cannot hang.

Parameters:
XLEN, 32, data/address width
SEL_LSB, 28, target index = addr[SEL_LSB+1:SEL_LSB]
TARGET_EN, 4'b1111, bit i=1 -> target i present; requests to absent targets return error
TIMEOUT, 255, cycles to wait for target response; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  initiator request valid
req_ready  output  1  request accepted this cycle when req_valid & req_ready
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  write data
req_we  input  1  1=write, 0=read
req_be  input  4  byte enables
rsp_valid  output  1  one-cycle response pulse; initiator always accepts
rsp_rdata  output  XLEN  read data; 0 on writes and errors
rsp_err  output  1  1=timeout or absent target
t_valid  output  4  per-target request valid, one-hot or zero
t_ready  input  4  per-target request ready
t_addr  output  XLEN  broadcast req_addr
t_wdata  output  XLEN  broadcast req_wdata
t_we  output  1  broadcast req_we
t_be  output  4  broadcast req_be
t_rsp_valid  input  4  per-target response valid
t_rdata  input  4*XLEN  target i data in bits [i*XLEN +: XLEN]

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel_q=0, timer=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Combinational outputs evaluate per IDLE with no request.
- sel = req_addr[SEL_LSB+1:SEL_LSB]. t_addr, t_wdata, t_we and t_be are combinational copies of the request fields in every state.
- States: IDLE, WAIT, RESP.
- IDLE, TARGET_EN[sel]=1:
  - t_valid[sel] = req_valid, other bits 0; req_ready = t_ready[sel].
  - On handshake: sel_q<=sel, timer<=0, ->WAIT.
- IDLE, TARGET_EN[sel]=0:
  - t_valid=0, req_ready=1.
  - On req_valid: rdata_q<=0, err_q<=1, ->RESP.
- WAIT: req_ready=0, t_valid=0. t_rsp_valid of non-selected targets is ignored.
  - t_rsp_valid[sel_q]=1: rdata_q <= req_we_q ? 0 : t_rdata[sel_q], err_q<=0, ->RESP. req_we_q is latched at accept.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: rdata_q<=0, err_q<=1, ->RESP.
  - Else timer<=timer+1.
  - Response and timeout in the same cycle: response wins, err=0.
- RESP: rsp_valid=1, rsp_rdata=rdata_q, rsp_err=err_q, all registered. req_ready=0. ->IDLE next cycle.
- rsp_valid is high for exactly one cycle per accepted request. Outside RESP: rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency: target response at edge N -> rsp_valid high in cycle N+1. Absent target: request accept at N -> rsp in N+1.
- Back-to-back: a new request is accepted no earlier than the cycle after RESP, i.e. one idle slot minimum between transactions.
- Timer width is $clog2(TIMEOUT+1), minimum 1; it saturates and does not wrap.
- Reset mid-transaction returns to IDLE. A late target response arriving in IDLE is ignored and produces no rsp_valid.
- t_ready is sampled only in IDLE. Target i must not pulse t_rsp_valid without an accepted request; if it does, the pulse is ignored unless i==sel_q in WAIT.

Test Plan:
- Read target 2: addr=0x2000_0010, t_ready=4'b0100 -> t_valid=4'b0100 and accept same cycle; t_rsp_valid[2] with rdata=0xDEAD_BEEF two cycles later -> rsp_valid next cycle, rdata=0xDEAD_BEEF, err=0.
- Write target 0 with t_ready[0] low for 3 cycles -> req_ready=0 and t_valid=4'b0001 held for 3 cycles; accept on 4th; response -> rsp_rdata=0, err=0, t_wdata/t_be match the request.
- TIMEOUT=4, target 1 never responds -> rsp_valid with err=1, rdata=0 exactly 5 cycles after accept; spurious t_rsp_valid[3] during WAIT is ignored.
- TARGET_EN=4'b0111, request to addr 0x3000_0000 -> req_ready=1, t_valid=0, rsp_valid next cycle with err=1.
- Response on cycle timer==TIMEOUT-1 -> err=0 with target data; rst_n pulsed low in WAIT, then t_rsp_valid[sel] arrives -> no rsp_valid; all outputs at reset values.
- Two back-to-back reads to targets 3 then 0 -> second accepted the cycle after the first RESP; rsp data correctly attributed to each.

Source files
------------

// File: rtl/bus_demux_1_4.sv
// One-initiator, four-target data bus demux with a single outstanding transaction.
// Absent targets and silent targets both resolve to an error response.
module bus_demux_1_4 #(
    parameter int         XLEN      = 32,
    parameter int         SEL_LSB   = 28,
    parameter logic [3:0] TARGET_EN = 4'b1111,
    parameter int         TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        t_valid,
    input  logic [3:0]        t_ready,
    output logic [XLEN-1:0]   t_addr,
    output logic [XLEN-1:0]   t_wdata,
    output logic              t_we,
    output logic [3:0]        t_be,
    input  logic [3:0]        t_rsp_valid,
    input  logic [4*XLEN-1:0] t_rdata
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = (TIMEOUT < 1) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMAX  = '1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel, sel_q;
    logic [TW-1:0]        timer_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 err_q;
    logic                 we_q;
    logic                 tmo;
    logic [3:0][XLEN-1:0] trd;

    assign trd     = t_rdata;
    assign sel     = req_addr[SEL_LSB+1:SEL_LSB];
    assign t_addr  = req_addr;
    assign t_wdata = req_wdata;
    assign t_we    = req_we;
    assign t_be    = req_be;
    assign tmo     = (TIMEOUT != 0) && (timer_q == TLAST);

    always_comb begin
        state_d   = state_q;
        t_valid   = '0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (TARGET_EN[sel]) begin
                    t_valid[sel] = req_valid;
                    req_ready    = t_ready[sel];
                    if (req_valid && t_ready[sel]) state_d = WAIT;
                end else begin
                    // absent target: swallow the request and answer with an error
                    req_ready = 1'b1;
                    if (req_valid) state_d = RESP;
                end
            end
            WAIT:    if (t_rsp_valid[sel_q] || tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            timer_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (TARGET_EN[sel]) begin
                            if (t_ready[sel]) begin
                                sel_q   <= sel;
                                timer_q <= '0;
                                we_q    <= req_we;
                            end
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // a real response beats a timeout landing in the same cycle
                    if (t_rsp_valid[sel_q]) begin
                        rdata_q <= we_q ? '0 : trd[sel_q];
                        err_q   <= 1'b0;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (timer_q != TMAX) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_bus_demux_1_4.sv
// Randomized bench for bus_demux_1_4 with a transaction-level reference model.
module tb_bus_demux_1_4;
    localparam int         XLEN = 32;
    localparam int         TMO  = 4;
    localparam logic [3:0] TEN  = 4'b0111;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid, rsp_err, t_we;
    logic [XLEN-1:0]   rsp_rdata, t_addr, t_wdata;
    logic [3:0]        t_valid, t_ready, t_be, t_rsp_valid;
    logic [4*XLEN-1:0] t_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_demux_1_4 #(.XLEN(XLEN), .SEL_LSB(28), .TARGET_EN(TEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .t_valid(t_valid), .t_ready(t_ready), .t_addr(t_addr), .t_wdata(t_wdata),
        .t_we(t_we), .t_be(t_be), .t_rsp_valid(t_rsp_valid), .t_rdata(t_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One full transaction: request phase, wait phase, response cycle.
    // rdly = cycles t_ready is held low; sdly = wait cycle the target answers in.
    task automatic txn(input logic [1:0] tgt, input logic we, input int rdly, input int sdly,
                       input bit spur, input bit fix, input logic [31:0] fval);
        logic [3:0]  onehot;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        bit          present, exp_err, hit;
        int          last;
        onehot    = 4'b0001 << tgt;
        present   = TEN[tgt];
        exp_err   = !present || (sdly >= TMO);
        exp_rdata = '0;
        last      = present ? rdly : 0;

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = $urandom;
        req_addr[29:28] = tgt;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        for (int c = 0; c <= last; c++) begin
            t_ready = 4'($urandom) & ~onehot;
            if (c == last) t_ready = t_ready | onehot;
            t_rsp_valid = '0;
            #1;
            chk("req_ready", req_ready, present ? (c == last) : 1'b1);
            chk("t_valid", t_valid, present ? onehot : 4'b0);
            chk("t_bcast", {t_addr, t_wdata, t_we, t_be}, {req_addr, req_wdata, req_we, req_be});
            chk("rsp_idle", {rsp_valid, rsp_err, rsp_rdata}, '0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        t_ready   = '0;

        if (present) begin
            for (int k = 0; k < TMO; k++) begin
                hit = (k == sdly);
                t_rdata = {$urandom, $urandom, $urandom, $urandom};
                data = t_rdata[tgt*XLEN +: XLEN];
                if (hit && fix) begin
                    t_rdata[tgt*XLEN +: XLEN] = fval;
                    data = fval;
                end
                t_rsp_valid = hit ? onehot : 4'b0;
                if (spur) t_rsp_valid = t_rsp_valid | (4'($urandom) & ~onehot);
                if (hit && !we) exp_rdata = data;
                #1;
                chk("wait_rsp", rsp_valid, 1'b0);
                chk("wait_rdy", req_ready, 1'b0);
                chk("wait_tv", t_valid, 4'b0);
                @(negedge clk);
                if (hit) break;
            end
        end

        t_rsp_valid = '0;
        #1;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_err ? 32'h0 : exp_rdata);
        chk("resp_rdy", req_ready, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        t_ready = '0; t_rsp_valid = '0; t_rdata = '0;
        #12;
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("rst_tv", t_valid, 4'b0);
        chk("rst_rdy", req_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(2'd2, 1'b0, 0, 2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        txn(2'd0, 1'b1, 3, 1, 1'b0, 1'b0, 32'h0);
        txn(2'd1, 1'b0, 0, 99, 1'b1, 1'b0, 32'h0);
        txn(2'd3, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
        txn(2'd1, 1'b0, 1, TMO - 1, 1'b1, 1'b1, 32'h1234_5678);
        txn(2'd2, 1'b0, 0, 0, 1'b0, 1'b1, 32'hAAAA_0003);
        txn(2'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h5555_0000);

        // late response after a timeout must not produce a second rsp
        txn(2'd2, 1'b0, 0, 99, 1'b0, 1'b0, 32'h0);
        t_rsp_valid = 4'b0100;
        @(negedge clk);
        t_rsp_valid = '0;
        #1;
        chk("late_rsp", rsp_valid, 1'b0);
        @(negedge clk);

        // reset while waiting on target 1
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0040; t_ready = 4'b0010;
        @(negedge clk);
        req_valid = 1'b0; t_ready = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        t_rsp_valid = 4'b0010;
        t_rdata = {4{32'hFEED_F00D}};
        @(negedge clk);
        t_rsp_valid = '0;
        #1;
        chk("post_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("post_rst_tv", t_valid, 4'b0);
        @(negedge clk);

        for (int i = 0; i < 60; i++)
            txn(2'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, TMO + 1)), 1'($urandom), 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
